wb_to_obi_pipe: RTL and testbench

- Parametrised successor to the single-transfer Wishbone-to-OBI bridge.
- Accepts a Wishbone B4 *pipelined* master (stb/stall) and drives an OBI slave.
- Supports up to MAX_OUTSTANDING in-flight transfers, OBI error responses and safe abort on cyc drop.
- Same clock domain on both sides; any clock-domain crossing is external.

---
 rtl/wb_to_obi_pipe.sv | 96 +++++++++
 tb/tb_wb_to_obi_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_to_obi_pipe.sv
// Pipelined Wishbone B4 master to OBI slave bridge. It tracks up to MAX_OUTSTANDING
// in-flight transfers and drains, without acknowledging, any responses still owed after cyc drops.
module wb_to_obi_pipe #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    localparam int BE_W           = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [BE_W-1:0]   wbs_sel_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_stall_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [DATA_W-1:0] wbs_dat_o,

    output logic              req_o,
    input  logic              gnt_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              err_i,
    output logic              spurious_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             dsc_reg;
    logic             dsc_next;
    logic             spurious_reg;

    logic full;
    logic accept;
    logic resp;
    logic resp_fwd;

    assign full = (cnt_reg == CNT_MAX);

    // Gating with rst_ni keeps the request idle while reset is held, whatever the master drives.
    assign req_o       = rst_ni & wbs_cyc_i & wbs_stb_i & ~full & ~dsc_reg;
    assign wbs_stall_o = full | dsc_reg | ~gnt_i;
    assign accept      = req_o & gnt_i;
    assign resp        = rvalid_i & (cnt_reg != '0);

    assign addr_o  = wbs_adr_i;
    assign we_o    = wbs_we_i;
    assign be_o    = wbs_sel_i;
    assign wdata_o = wbs_dat_i;

    // Responses are forwarded in the same cycle; OBI keeps them in request order.
    assign resp_fwd  = resp & ~dsc_reg & wbs_cyc_i;
    assign wbs_ack_o = resp_fwd & ~err_i;
    assign wbs_err_o = resp_fwd & err_i;
    assign wbs_dat_o = rdata_i;

    assign spurious_o = spurious_reg;

    always_comb begin
        cnt_next = cnt_reg;
        case ({accept, resp})
            2'b10:   cnt_next = cnt_reg + CNT_ONE;
            2'b01:   cnt_next = cnt_reg - CNT_ONE;
            default: cnt_next = cnt_reg;
        endcase
    end

    // Discard mode is entered when the master abandons the cycle with responses still owed,
    // and is left exactly when the last owed response has been absorbed.
    assign dsc_next = (cnt_next != '0) & (dsc_reg | ~wbs_cyc_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg      <= '0;
            dsc_reg      <= 1'b0;
            spurious_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            dsc_reg      <= dsc_next;
            spurious_reg <= rvalid_i & (cnt_reg == '0);
        end
    end

endmodule

// File: tb/tb_wb_to_obi_pipe.sv
// Directed bench for wb_to_obi_pipe: inputs change on the falling edge and
// outputs are checked 1 ns later, well clear of the rising edge.
module tb_wb_to_obi_pipe;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [BE_W-1:0]   wbs_sel_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_stall_o, wbs_ack_o, wbs_err_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic              req_o, gnt_i, we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [BE_W-1:0]   be_o;
    logic [DATA_W-1:0] wdata_o;
    logic              rvalid_i, err_i, spurious_o;
    logic [DATA_W-1:0] rdata_i;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    wb_to_obi_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_stall_o(wbs_stall_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbs_dat_o(wbs_dat_o),
        .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
        .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
        .spurious_o(spurious_o)
    );

    task automatic drive_idle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = '0;
        wbs_adr_i = '0;   wbs_dat_i = '0;   gnt_i = 1'b1;   rvalid_i = 1'b0;
        rdata_i = '0;     err_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive_idle();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; rvalid_i = 1'b1;
        next_cycle(); next_cycle();
        #1;
        tests_run++; if (req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", req_o); end
        tests_run++; if (wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack_err: got %b%b expected 00", wbs_ack_o, wbs_err_o); end
        tests_run++; if (spurious_o !== 1'b0) begin tests_failed++; $display("FAIL reset_spurious: got %b expected 0", spurious_o); end
        tests_run++; if (dut.cnt_reg !== 2'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_reg); end
        next_cycle();
        drive_idle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_read();
        int reqs = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h100; gnt_i = 1'b1;
        #1;
        reqs += int'(req_o);
        tests_run++; if (wbs_stall_o !== 1'b0) begin tests_failed++; $display("FAIL rd_stall: got %b expected 0", wbs_stall_o); end
        tests_run++; if (addr_o !== 32'h100 || we_o !== 1'b0) begin tests_failed++; $display("FAIL rd_addr: got %h/%b expected 00000100/0", addr_o, we_o); end
        next_cycle();
        wbs_stb_i = 1'b0; gnt_i = 1'b0;
        #1;
        reqs += int'(req_o);
        tests_run++; if (wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rd_early_ack: got %b expected 0", wbs_ack_o); end
        tests_run++; if (dut.cnt_reg !== 2'd1) begin tests_failed++; $display("FAIL rd_cnt1: got %0d expected 1", dut.cnt_reg); end
        next_cycle();
        rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF;
        #1;
        reqs += int'(req_o);
        tests_run++; if (wbs_ack_o !== 1'b1 || wbs_err_o !== 1'b0) begin tests_failed++; $display("FAIL rd_ack: got ack=%b err=%b expected 1/0", wbs_ack_o, wbs_err_o); end
        tests_run++; if (wbs_dat_o !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_data: got %h expected deadbeef", wbs_dat_o); end
        next_cycle();
        drive_idle();
        #1;
        tests_run++; if (reqs != 1) begin tests_failed++; $display("FAIL rd_req_count: got %0d expected 1", reqs); end
        tests_run++; if (dut.cnt_reg !== 2'd0 || wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rd_drained: got cnt=%0d ack=%b expected 0/0", dut.cnt_reg, wbs_ack_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; gnt_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wbs_adr_i = 32'h200 + 32'(4 * i); wbs_dat_i = 32'h1000 + 32'(i);
            #1;
            tests_run++; if (req_o !== 1'b1 || wbs_stall_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept%0d: got req=%b stall=%b expected 1/0", i, req_o, wbs_stall_o); end
            next_cycle();
        end
        wbs_adr_i = 32'h208; wbs_dat_i = 32'h1002;
        #1;
        tests_run++; if (req_o !== 1'b0 || wbs_stall_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_full: got req=%b stall=%b expected 0/1", req_o, wbs_stall_o); end
        next_cycle();
        rvalid_i = 1'b1;
        #1;
        acks += int'(wbs_ack_o);
        next_cycle();
        rvalid_i = 1'b0;
        #1;
        tests_run++; if (req_o !== 1'b1 || wbs_stall_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_third: got req=%b stall=%b expected 1/0", req_o, wbs_stall_o); end
        next_cycle();
        wbs_stb_i = 1'b0;
        #1;
        tests_run++; if (dut.cnt_reg !== 2'd2) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected 2", dut.cnt_reg); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rvalid_i = (i < 2);
            #1;
            acks += int'(wbs_ack_o);
        end
        tests_run++; if (acks != 3) begin tests_failed++; $display("FAIL b2b_acks: got %0d expected 3", acks); end
        tests_run++; if (dut.cnt_reg !== 2'd0) begin tests_failed++; $display("FAIL b2b_drain: got %0d expected 0", dut.cnt_reg); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_gnt_stall();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'h5;
        wbs_adr_i = 32'h300; wbs_dat_i = 32'hCAFE_F00D; gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (wbs_stall_o !== 1'b1 || req_o !== 1'b1) begin tests_failed++; $display("FAIL gnt_wait%0d: got stall=%b req=%b expected 1/1", i, wbs_stall_o, req_o); end
            tests_run++; if (addr_o !== 32'h300 || we_o !== 1'b1 || be_o !== 4'h5 || wdata_o !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL gnt_fields%0d: got %h/%b/%h/%h expected 00000300/1/5/cafef00d", i, addr_o, we_o, be_o, wdata_o); end
            tests_run++; if (dut.cnt_reg !== 2'd0) begin tests_failed++; $display("FAIL gnt_cnt%0d: got %0d expected 0", i, dut.cnt_reg); end
            next_cycle();
        end
        gnt_i = 1'b1;
        #1;
        tests_run++; if (wbs_stall_o !== 1'b0) begin tests_failed++; $display("FAIL gnt_release: got %b expected 0", wbs_stall_o); end
        next_cycle();
        wbs_stb_i = 1'b0; rvalid_i = 1'b1;
        #1;
        tests_run++; if (wbs_ack_o !== 1'b1) begin tests_failed++; $display("FAIL gnt_ack: got %b expected 1", wbs_ack_o); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_error();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h400; gnt_i = 1'b1;
        next_cycle();
        wbs_stb_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b1;
        #1;
        tests_run++; if (wbs_err_o !== 1'b1 || wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL err_resp: got err=%b ack=%b expected 1/0", wbs_err_o, wbs_ack_o); end
        next_cycle();
        rvalid_i = 1'b0; err_i = 1'b0;
        #1;
        tests_run++; if (dut.cnt_reg !== 2'd0) begin tests_failed++; $display("FAIL err_cnt: got %0d expected 0", dut.cnt_reg); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_abort();
        int acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; gnt_i = 1'b1;
        wbs_adr_i = 32'h480; next_cycle();
        wbs_adr_i = 32'h484; next_cycle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        next_cycle();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h500;
        #1;
        tests_run++; if (wbs_stall_o !== 1'b1 || req_o !== 1'b0) begin tests_failed++; $display("FAIL abort_stall: got stall=%b req=%b expected 1/0", wbs_stall_o, req_o); end
        tests_run++; if (dut.dsc_reg !== 1'b1) begin tests_failed++; $display("FAIL abort_dsc: got %b expected 1", dut.dsc_reg); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            rvalid_i = 1'b1;
            #1;
            acks += int'(wbs_ack_o) + int'(wbs_err_o);
            tests_run++; if (wbs_stall_o !== 1'b1 || req_o !== 1'b0) begin tests_failed++; $display("FAIL abort_drain%0d: got stall=%b req=%b expected 1/0", i, wbs_stall_o, req_o); end
        end
        tests_run++; if (acks != 0) begin tests_failed++; $display("FAIL abort_acks: got %0d expected 0", acks); end
        next_cycle();
        rvalid_i = 1'b0;
        #1;
        tests_run++; if (req_o !== 1'b1 || wbs_stall_o !== 1'b0 || dut.dsc_reg !== 1'b0) begin tests_failed++; $display("FAIL abort_resume: got req=%b stall=%b dsc=%b expected 1/0/0", req_o, wbs_stall_o, dut.dsc_reg); end
        next_cycle();
        wbs_stb_i = 1'b0;
        next_cycle();
        rvalid_i = 1'b1; rdata_i = 32'h0000_0500;
        #1;
        tests_run++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h500) begin tests_failed++; $display("FAIL abort_new_ack: got ack=%b dat=%h expected 1/00000500", wbs_ack_o, wbs_dat_o); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_spurious();
        rvalid_i = 1'b1; wbs_cyc_i = 1'b1;
        #1;
        tests_run++; if (wbs_ack_o !== 1'b0 || spurious_o !== 1'b0) begin tests_failed++; $display("FAIL spur_same: got ack=%b spur=%b expected 0/0", wbs_ack_o, spurious_o); end
        next_cycle();
        rvalid_i = 1'b0;
        #1;
        tests_run++; if (spurious_o !== 1'b1 || dut.cnt_reg !== 2'd0) begin tests_failed++; $display("FAIL spur_pulse: got spur=%b cnt=%0d expected 1/0", spurious_o, dut.cnt_reg); end
        next_cycle();
        #1;
        tests_run++; if (spurious_o !== 1'b0) begin tests_failed++; $display("FAIL spur_end: got %b expected 0", spurious_o); end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h600; gnt_i = 1'b1;
        next_cycle();
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        #1;
        tests_run++; if (dut.cnt_reg !== 2'd1) begin tests_failed++; $display("FAIL rstmid_pre: got %0d expected 1", dut.cnt_reg); end
        rst_ni = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        #1;
        tests_run++; if (dut.cnt_reg !== 2'd0 || dut.dsc_reg !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state: got cnt=%0d dsc=%b expected 0/0", dut.cnt_reg, dut.dsc_reg); end
        tests_run++; if (req_o !== 1'b0 || wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle: got req=%b ack=%b expected 0/0", req_o, wbs_ack_o); end
        next_cycle();
        drive_idle();
        rst_ni = 1'b1;
        wbs_cyc_i = 1'b1; rvalid_i = 1'b1;
        #1;
        tests_run++; if (wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_late_ack: got %b expected 0", wbs_ack_o); end
        next_cycle();
        rvalid_i = 1'b0;
        #1;
        tests_run++; if (spurious_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_spur: got %b expected 1", spurious_o); end
        drive_idle();
        next_cycle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        rst_ni = 1'b0;
        next_cycle();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_gnt_stall();
        test_error();
        test_abort();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
